alu_seq: RTL and testbench

- Parametrised, sequential successor to the datapath's combinational ALU. Uses the same 6-bit opcode map.
- Adds a valid/ready handshake on input and output, a registered result, status flags, and iterative multi-cycle MUL/DIV/MOD.
- Sits between the register-file read stage and writeback. The control unit stalls on in_ready/out_valid.

---
 rtl/alu_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_alu_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshake, registered result and flags,
// and iterative shift-add multiply / restoring divide.
module alu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] regA,
  input  logic [WIDTH-1:0] regB,
  input  logic [5:0]       aluOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             div_zero
);

  localparam int unsigned CNTW = SHW + 1;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_AND   = 6'b000001;
  localparam logic [5:0] OP_DIV   = 6'b000010;
  localparam logic [5:0] OP_MOD   = 6'b000011;
  localparam logic [5:0] OP_MUL   = 6'b000100;
  localparam logic [5:0] OP_NAND  = 6'b000101;
  localparam logic [5:0] OP_NOR   = 6'b000110;
  localparam logic [5:0] OP_NOT   = 6'b000111;
  localparam logic [5:0] OP_OR    = 6'b001000;
  localparam logic [5:0] OP_SGT   = 6'b001001;
  localparam logic [5:0] OP_SGET  = 6'b001010;
  localparam logic [5:0] OP_SLL   = 6'b001011;
  localparam logic [5:0] OP_SLR   = 6'b001100;
  localparam logic [5:0] OP_SLT   = 6'b001101;
  localparam logic [5:0] OP_SLTEQ = 6'b001110;
  localparam logic [5:0] OP_SUB   = 6'b001111;
  localparam logic [5:0] OP_XNOR  = 6'b010000;
  localparam logic [5:0] OP_XOR   = 6'b010001;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  stateT            stateQ, stateD;
  logic             initQ;
  logic [5:0]       opQ, opD;
  logic [WIDTH-1:0] operandQ, operandD;
  logic [WIDTH-1:0] hiQ, hiD, loQ, loD;
  logic [CNTW-1:0]  cntQ, cntD;
  logic [WIDTH-1:0] resultD;
  logic             zeroD, carryD, overflowD, divZeroD, outValidD;

  logic             accept;
  logic [WIDTH:0]   sumFull, diffFull;
  logic [WIDTH-1:0] quickRes;
  logic             quickCarry, quickOvf, quickDivZero, quickMulti;

  logic [WIDTH:0]   mulSum, divPartial;
  logic [WIDTH-1:0] divTrial, iterHi, iterLo;
  logic             divGe;

  // in_ready stays low until the first cycle after reset releases
  always_comb begin
    in_ready = initQ && ((stateQ == IDLE) || ((stateQ == DONE) && out_ready));
    accept   = in_valid && in_ready;
  end

  // Single-cycle results, computed straight from the presented operands
  always_comb begin
    sumFull      = {1'b0, regA} + {1'b0, regB};
    diffFull     = {1'b0, regA} - {1'b0, regB};
    quickRes     = regA;
    quickCarry   = 1'b0;
    quickOvf     = 1'b0;
    quickDivZero = 1'b0;
    quickMulti   = 1'b0;
    case (aluOp)
      OP_ADD: begin
        quickRes   = sumFull[WIDTH-1:0];
        quickCarry = sumFull[WIDTH];
        quickOvf   = (regA[WIDTH-1] == regB[WIDTH-1]) && (sumFull[WIDTH-1] != regA[WIDTH-1]);
      end
      OP_SUB: begin
        quickRes   = diffFull[WIDTH-1:0];
        quickCarry = diffFull[WIDTH];
        quickOvf   = (regA[WIDTH-1] != regB[WIDTH-1]) && (diffFull[WIDTH-1] != regA[WIDTH-1]);
      end
      OP_DIV: begin
        if (regB == '0) begin
          quickRes     = '1;
          quickDivZero = 1'b1;
        end else begin
          quickMulti = 1'b1;
        end
      end
      OP_MOD: begin
        if (regB == '0) begin
          quickRes     = regA;
          quickDivZero = 1'b1;
        end else begin
          quickMulti = 1'b1;
        end
      end
      OP_MUL:   quickMulti = 1'b1;
      OP_AND:   quickRes = regA & regB;
      OP_NAND:  quickRes = ~(regA & regB);
      OP_NOR:   quickRes = ~(regA | regB);
      OP_NOT:   quickRes = ~regA;
      OP_OR:    quickRes = regA | regB;
      OP_SGT:   quickRes = {{(WIDTH-1){1'b0}}, (regA > regB)};
      OP_SGET:  quickRes = {{(WIDTH-1){1'b0}}, (regA >= regB)};
      OP_SLT:   quickRes = {{(WIDTH-1){1'b0}}, (regA < regB)};
      OP_SLTEQ: quickRes = {{(WIDTH-1){1'b0}}, (regA <= regB)};
      OP_SLL:   quickRes = (regB >= WIDTH'(WIDTH)) ? '0 : (regA << regB[SHW-1:0]);
      OP_SLR:   quickRes = (regB >= WIDTH'(WIDTH)) ? '0 : (regA >> regB[SHW-1:0]);
      OP_XNOR:  quickRes = ~(regA ^ regB);
      OP_XOR:   quickRes = regA ^ regB;
      default:  quickRes = regA;
    endcase
  end

  // One multiply or divide step; {hiQ,loQ} is the product or {remainder,quotient}
  always_comb begin
    mulSum     = {1'b0, hiQ} + (loQ[0] ? {1'b0, operandQ} : '0);
    divPartial = {hiQ, loQ[WIDTH-1]};
    divGe      = divPartial >= {1'b0, operandQ};
    divTrial   = divPartial[WIDTH-1:0] - operandQ;
    if (opQ == OP_MUL) begin
      iterHi = mulSum[WIDTH:1];
      iterLo = {mulSum[0], loQ[WIDTH-1:1]};
    end else begin
      iterHi = divGe ? divTrial : divPartial[WIDTH-1:0];
      iterLo = {loQ[WIDTH-2:0], divGe};
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    stateD    = stateQ;
    opD       = opQ;
    operandD  = operandQ;
    hiD       = hiQ;
    loD       = loQ;
    cntD      = cntQ;
    resultD   = result;
    zeroD     = zero;
    carryD    = carry;
    overflowD = overflow;
    divZeroD  = div_zero;
    outValidD = out_valid;

    case (stateQ)
      BUSY: begin
        hiD  = iterHi;
        loD  = iterLo;
        cntD = cntQ - CNTW'(1);
        // Last step folds straight into the registered result
        if (cntQ == CNTW'(1)) begin
          resultD   = (opQ == OP_MOD) ? iterHi : iterLo;
          zeroD     = (resultD == '0);
          carryD    = 1'b0;
          overflowD = (opQ == OP_MUL) && (iterHi != '0);
          divZeroD  = 1'b0;
          outValidD = 1'b1;
          stateD    = DONE;
        end
      end
      DONE: begin
        if (out_ready && !accept) begin
          outValidD = 1'b0;
          stateD    = IDLE;
        end
      end
      default: ;
    endcase

    if (accept) begin
      opD = aluOp;
      if (quickMulti) begin
        operandD  = (aluOp == OP_MUL) ? regA : regB;
        loD       = (aluOp == OP_MUL) ? regB : regA;
        hiD       = '0;
        cntD      = CNTW'(WIDTH);
        outValidD = 1'b0;
        stateD    = BUSY;
      end else begin
        resultD   = quickRes;
        zeroD     = (quickRes == '0);
        carryD    = quickCarry;
        overflowD = quickOvf;
        divZeroD  = quickDivZero;
        outValidD = 1'b1;
        stateD    = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ    <= IDLE;
      initQ     <= 1'b0;
      opQ       <= '0;
      operandQ  <= '0;
      hiQ       <= '0;
      loQ       <= '0;
      cntQ      <= '0;
      result    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      div_zero  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      stateQ    <= stateD;
      initQ     <= 1'b1;
      opQ       <= opD;
      operandQ  <= operandD;
      hiQ       <= hiD;
      loQ       <= loD;
      cntQ      <= cntD;
      result    <= resultD;
      zero      <= zeroD;
      carry     <= carryD;
      overflow  <= overflowD;
      div_zero  <= divZeroD;
      out_valid <= outValidD;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq; expected results queue in a scoreboard
// and a negedge monitor pops them whenever a result transfer is about to happen.
module tb_alu_seq;

  localparam int unsigned W = 32;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_AND  = 6'b000001;
  localparam logic [5:0] OP_DIV  = 6'b000010;
  localparam logic [5:0] OP_MOD  = 6'b000011;
  localparam logic [5:0] OP_MUL  = 6'b000100;
  localparam logic [5:0] OP_NOR  = 6'b000110;
  localparam logic [5:0] OP_NOT  = 6'b000111;
  localparam logic [5:0] OP_SGT  = 6'b001001;
  localparam logic [5:0] OP_SLL  = 6'b001011;
  localparam logic [5:0] OP_SLR  = 6'b001100;
  localparam logic [5:0] OP_SLT  = 6'b001101;
  localparam logic [5:0] OP_SUB  = 6'b001111;
  localparam logic [5:0] OP_XOR  = 6'b010001;
  localparam logic [5:0] OP_UNK  = 6'b111111;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] regA = '0;
  logic [W-1:0] regB = '0;
  logic [5:0]   aluOp = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         zero, carry, overflow, div_zero;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .regA      (regA),
    .regB      (regB),
    .aluOp     (aluOp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .div_zero  (div_zero)
  );

  // flags are packed {zero, carry, overflow, div_zero}
  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   flags;
  } exp_t;

  exp_t  expQ[$];
  string nameQ[$];
  int    nChecks = 0;
  int    nFails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens on the next rising edge when valid and ready are both high
  always @(negedge clk) begin
    exp_t  e;
    string n;
    if (rst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL unexpected_output: got result 0x%0h, expected no transfer", result);
      end else begin
        e = expQ.pop_front();
        n = nameQ.pop_front();
        check({n, "_result"}, 64'(result), 64'(e.res));
        check({n, "_flags"}, 64'({zero, carry, overflow, div_zero}), 64'(e.flags));
      end
    end
  end

  task automatic issue(input string name, input logic [5:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eRes,
                       input logic [3:0] eFlags, input bit push);
    int budget = 0;
    regA     = a;
    regB     = b;
    aluOp    = op;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      check({name, "_accept_timeout"}, 64'(in_ready), 64'(1));
    end else if (push) begin
      expQ.push_back({eRes, eFlags});
      nameQ.push_back(name);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Called #1 after the accepting edge; latency 1 means out_valid is already high
  task automatic waitValid(input string name, input int expLat);
    int n = 1;
    bit readyLeak = 1'b0;
    while (!out_valid && n < 200) begin
      if (in_ready) readyLeak = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(expLat));
    if (expLat > 1) check({name, "_in_ready_busy"}, 64'(readyLeak), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit sawValid;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(0));
    check("reset_result", 64'(result), 64'(0));
    check("reset_flags", 64'({zero, carry, overflow, div_zero}), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", 64'(in_ready), 64'(1));

    issue("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b1100, 1'b1);
    waitValid("add_wrap", 1);

    issue("sub_ovf", OP_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'b0010, 1'b1);
    waitValid("sub_ovf", 1);
    check("b2b_in_ready", 64'(in_ready), 64'(1));
    issue("xor_b2b", OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 4'b0000, 1'b1);
    waitValid("xor_b2b", 1);

    issue("mul_ovf", OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0, 4'b1010, 1'b1);
    waitValid("mul_ovf", 33);
    issue("mul_small", OP_MUL, 32'd7, 32'd6, 32'd42, 4'b0000, 1'b1);
    waitValid("mul_small", 33);

    issue("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd14, 4'b0000, 1'b1);
    waitValid("div_100_7", 33);
    issue("mod_100_7", OP_MOD, 32'd100, 32'd7, 32'd2, 4'b0000, 1'b1);
    waitValid("mod_100_7", 33);
    issue("div_by0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 4'b0001, 1'b1);
    waitValid("div_by0", 1);
    issue("mod_by0", OP_MOD, 32'd5, 32'd0, 32'd5, 4'b0001, 1'b1);
    waitValid("mod_by0", 1);

    issue("and", OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 4'b0000, 1'b1);
    issue("slt_true", OP_SLT, 32'd3, 32'd5, 32'd1, 4'b0000, 1'b1);
    issue("sgt_false", OP_SGT, 32'd3, 32'd5, 32'd0, 4'b1000, 1'b1);
    issue("sgt_true", OP_SGT, 32'd5, 32'd3, 32'd1, 4'b0000, 1'b1);
    issue("slr_4", OP_SLR, 32'h8000_0000, 32'd4, 32'h0800_0000, 4'b0000, 1'b1);
    issue("nor_zero", OP_NOR, 32'h0, 32'h0, 32'hFFFF_FFFF, 4'b0000, 1'b1);
    issue("not", OP_NOT, 32'h0000_FFFF, 32'h0, 32'hFFFF_0000, 4'b0000, 1'b1);
    waitValid("not", 1);

    // Let the pending result transfer, then stall the consumer
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue("sll_31", OP_SLL, 32'h1, 32'd31, 32'h8000_0000, 4'b0000, 1'b1);
    waitValid("sll_31", 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_result", 64'(result), 64'h8000_0000);
      check("stall_in_ready", 64'(in_ready), 64'(0));
      check("stall_out_valid", 64'(out_valid), 64'(1));
    end
    out_ready = 1'b1;
    issue("sll_40", OP_SLL, 32'h1, 32'd40, 32'h0, 4'b1000, 1'b1);
    waitValid("sll_40", 1);

    issue("add_small", OP_ADD, 32'd3, 32'd4, 32'd7, 4'b0000, 1'b1);
    waitValid("add_small", 1);
    issue("div_aborted", OP_DIV, 32'd100, 32'd7, 32'd0, 4'b0000, 1'b0);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    check("pre_reset_result", 64'(result), 64'd7);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_result", 64'(result), 64'(0));
    check("abort_in_ready", 64'(in_ready), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_release_in_ready", 64'(in_ready), 64'(1));
    sawValid = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) sawValid = 1'b1;
    end
    check("abort_no_stale_valid", 64'(sawValid), 64'(0));

    issue("unknown_op", OP_UNK, 32'h0000_1234, 32'h0000_5678, 32'h0000_1234, 4'b0000, 1'b1);
    waitValid("unknown_op", 1);

    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 64'(expQ.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
